// File: rtl/alu_issue_unit.sv
// Three-state issue unit: accepts one instruction, drives a registered
// ALU operand set, captures the result and retires it to an 8x32 file.
module alu_issue_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_zf,
  input  logic        alu_nf,
  input  logic        alu_ef,
  input  logic        alu_gf,
  input  logic        alu_lf,
  output logic        done,
  output logic        err,
  output logic [4:0]  flags,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] rf_q [8];
  logic [3:0]  ctrl_q;
  logic [31:0] a_q, b_q;
  logic [31:0] res_q;
  logic [4:0]  fl_q;
  logic [4:0]  flags_q;
  logic [2:0]  rd_q;
  logic        err_q;

  logic [3:0]  op;
  logic [2:0]  rd, rs1, rs2;
  logic        imm_sel;
  logic [15:0] imm;
  logic        legal;
  logic        accept;
  logic [31:0] opa, opb;
  logic        unused_bits;

  assign op      = in_instr[31:28];
  assign rd      = in_instr[27:25];
  assign rs1     = in_instr[24:22];
  assign rs2     = in_instr[21:19];
  assign imm_sel = in_instr[16];
  assign imm     = in_instr[15:0];
  assign unused_bits = ^in_instr[18:17];

  assign legal  = (op <= 4'd9);
  assign accept = in_valid && in_ready;

  // r0 is never written, so a plain read returns zero
  assign opa = rf_q[rs1];
  assign opb = imm_sel ? {{16{imm[15]}}, imm} : rf_q[rs2];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = legal ? EXEC : WB;
      EXEC: state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      fl_q    <= '0;
      flags_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q  <= rd;
        err_q <= !legal;
      end
      if (accept && legal) begin
        ctrl_q <= op;
        a_q    <= opa;
        b_q    <= opb;
      end
      if (state_q == EXEC) begin
        res_q <= alu_res;
        fl_q  <= {alu_zf, alu_nf, alu_ef, alu_gf, alu_lf};
      end
      if (state_q == WB && !err_q) begin
        flags_q <= fl_q;
        if (rd_q != 3'd0) rf_q[rd_q] <= res_q;
      end
    end
  end

  assign in_ready = (state_q == IDLE) && !rst;
  assign done     = (state_q == WB);
  assign err      = done && err_q;
  assign flags    = flags_q;
  assign alu_ctrl = ctrl_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign dbg_data = (dbg_addr == 3'd0) ? 32'd0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU model
// closing the alu_* loop.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zf, alu_nf, alu_ef, alu_gf, alu_lf;
  logic        done, err;
  logic [4:0]  flags;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  alu_issue_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res),
    .alu_zf(alu_zf), .alu_nf(alu_nf), .alu_ef(alu_ef),
    .alu_gf(alu_gf), .alu_lf(alu_lf),
    .done(done), .err(err), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU: signed compares for G/L
  logic [31:0] r;
  always_comb begin
    r = 32'd0;
    case (alu_ctrl)
      4'd0: r = alu_a + alu_b;
      4'd1: r = alu_a - alu_b;
      4'd2: r = alu_a << alu_b[4:0];
      4'd3: r = alu_a >> alu_b[4:0];
      4'd4: r = alu_a & alu_b;
      4'd5: r = alu_a | alu_b;
      4'd6: r = alu_a ^ alu_b;
      4'd7: r = ~(alu_a & alu_b);
      4'd8: r = ~alu_a;
      4'd9: r = ~(alu_a | alu_b);
      default: r = 32'd0;
    endcase
    alu_res = r;
    alu_zf  = (r == 32'd0);
    alu_nf  = r[31];
    alu_ef  = (alu_a == alu_b);
    alu_gf  = ($signed(alu_a) > $signed(alu_b));
    alu_lf  = ($signed(alu_a) < $signed(alu_b));
  end

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  rd;
    logic [31:0] val;
    logic [4:0]  flg;
    logic        err;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [31:0] enc(input logic [3:0] op,
                                      input logic [2:0] rd,
                                      input logic [2:0] rs1,
                                      input logic [2:0] rs2,
                                      input logic       isel,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, 2'b00, isel, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr,
                              input logic [2:0]  rd,
                              input logic [31:0] val,
                              input logic [4:0]  flg,
                              input logic        e,
                              input logic [3:0]  ctrl,
                              input logic [31:0] a,
                              input logic [31:0] b);
    vec_t v;
    v.instr = instr; v.rd = rd; v.val = val; v.flg = flg;
    v.err = e; v.ctrl = ctrl; v.a = a; v.b = b;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 8) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
    in_instr = v.instr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!done && lat < 4) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("v%0d_latency", i), 32'(lat), v.err ? 32'd1 : 32'd2);
    chk($sformatf("v%0d_err", i), 32'(err), 32'(v.err));
    chk($sformatf("v%0d_ctrl", i), 32'(alu_ctrl), 32'(v.ctrl));
    chk($sformatf("v%0d_a", i), alu_a, v.a);
    chk($sformatf("v%0d_b", i), alu_b, v.b);
    chk($sformatf("v%0d_rdy_wb", i), 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    dbg_addr = v.rd;
    #1;
    chk($sformatf("v%0d_done_off", i), 32'(done), 32'd0);
    chk($sformatf("v%0d_err_off", i), 32'(err), 32'd0);
    chk($sformatf("v%0d_flags", i), 32'(flags), 32'(v.flg));
    chk($sformatf("v%0d_rd", i), dbg_data, v.val);
    chk($sformatf("v%0d_rdy_idle", i), 32'(in_ready), 32'd1);
  endtask

  logic [31:0] bb [4];
  int idx, last, pulses;
  logic acc;

  initial begin
    tbl[0]  = mk(enc(0,1,0,0,1,16'd5),      1, 32'd5,        5'b00001, 0, 0, 32'd0,  32'd5);
    tbl[1]  = mk(enc(0,2,1,0,1,16'hFFFB),   2, 32'd0,        5'b10010, 0, 0, 32'd5,  32'hFFFFFFFB);
    tbl[2]  = mk(enc(0,1,0,0,1,16'h00F0),   1, 32'hF0,       5'b00001, 0, 0, 32'd0,  32'hF0);
    tbl[3]  = mk(enc(3,3,1,0,1,16'd4),      3, 32'h0F,       5'b00010, 0, 3, 32'hF0, 32'd4);
    tbl[4]  = mk(enc(8,4,3,0,0,16'd0),      4, 32'hFFFFFFF0, 5'b01010, 0, 8, 32'h0F, 32'd0);
    tbl[5]  = mk(enc(12,3,1,2,0,16'd0),     3, 32'h0F,       5'b01010, 1, 8, 32'h0F, 32'd0);
    tbl[6]  = mk(enc(0,1,0,0,1,16'd7),      1, 32'd7,        5'b00001, 0, 0, 32'd0,  32'd7);
    tbl[7]  = mk(enc(0,0,1,1,0,16'd0),      0, 32'd0,        5'b00100, 0, 0, 32'd7,  32'd7);
    tbl[8]  = mk(enc(2,5,3,0,1,16'd4),      5, 32'hF0,       5'b00010, 0, 2, 32'h0F, 32'd4);
    tbl[9]  = mk(enc(6,6,5,3,0,16'd0),      6, 32'hFF,       5'b00010, 0, 6, 32'hF0, 32'h0F);
    tbl[10] = mk(enc(1,7,3,5,0,16'd0),      7, 32'hFFFFFF1F, 5'b01001, 0, 1, 32'h0F, 32'hF0);
    tbl[11] = mk(enc(4,2,5,6,0,16'd0),      2, 32'hF0,       5'b00001, 0, 4, 32'hF0, 32'hFF);
    tbl[12] = mk(enc(9,2,0,0,0,16'd0),      2, 32'hFFFFFFFF, 5'b01100, 0, 9, 32'd0,  32'd0);
    tbl[13] = mk(enc(0,1,1,0,1,16'd1),      1, 32'd8,        5'b00010, 0, 0, 32'd7,  32'd1);
    tbl[14] = mk(enc(5,3,5,0,1,16'h000F),   3, 32'hFF,       5'b00010, 0, 5, 32'hF0, 32'h0F);
    tbl[15] = mk(enc(7,4,5,6,0,16'd0),      4, 32'hFFFFFF0F, 5'b01001, 0, 7, 32'hF0, 32'hFF);

    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; dbg_addr = 3'd0;
    #2;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

    // back-to-back: valid held high across four instructions
    bb[0] = enc(0,1,0,0,1,16'd1);
    bb[1] = enc(0,1,1,0,1,16'd1);
    bb[2] = enc(0,1,1,0,1,16'd1);
    bb[3] = enc(0,1,1,0,1,16'd1);
    idx = 0; last = -1; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      in_instr = bb[(idx < 4) ? idx : 3];
      in_valid = (idx < 4);
      acc = in_ready && in_valid;
      @(posedge clk); #1;
      if (acc) idx++;
      chk($sformatf("bb_c%0d_rdy_done", c), 32'(in_ready & done), 32'd0);
      if (done) begin
        if (last >= 0) chk($sformatf("bb_gap%0d", pulses), 32'(c - last), 32'd3);
        last = c;
        pulses++;
      end
    end
    in_valid = 1'b0;
    chk("bb_pulses", 32'(pulses), 32'd4);
    dbg_addr = 3'd1;
    #1;
    chk("bb_r1", dbg_data, 32'd4);
    chk("bb_flags", 32'(flags), 32'(5'b00010));

    // reset while in EXEC aborts the instruction
    in_instr = enc(0,2,0,0,1,16'd9);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_exec_done", 32'(done), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_ready", 32'(in_ready), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_flags", 32'(flags), 32'd0);
    chk("mid_ctrl", 32'(alu_ctrl), 32'd0);
    chk("mid_a", alu_a, 32'd0);
    chk("mid_b", alu_b, 32'd0);
    @(posedge clk); #1;
    chk("mid_done2", 32'(done), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      dbg_addr = 3'(k);
      #1;
      chk($sformatf("mid_r%0d", k), dbg_data, 32'd0);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_nodone%0d", c), 32'(done), 32'd0);
    end
    run_vec(mk(enc(0,3,0,0,1,16'd3), 3, 32'd3, 5'b00001, 0, 0, 32'd0, 32'd3), 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset:
  clk  input  1  rising-edge clock, sole clock domain
  rst  input  1  asynchronous, active-high reset
REQ-002 The block SHALL have the following instruction input ports:
  in_valid  input  1   instruction word present
  in_instr  input  32  instruction word
  in_ready  output 1   unit can accept an instruction
REQ-003 The block SHALL have the following ALU drive ports, which feed the combinational ALU:
  alu_ctrl  output 4   ALU operation code
  alu_a     output 32  ALU operand A
  alu_b     output 32  ALU operand B
REQ-004 The block SHALL have the following ALU return ports, driven by the ALU:
  alu_res   input  32  ALU result
  alu_zf, alu_nf, alu_ef, alu_gf, alu_lf  input 1 each  ALU status flags
REQ-005 The block SHALL have the following completion ports:
  done  output 1   one-cycle pulse when an instruction retires
  err   output 1   valid with done; 1 = illegal opcode
  flags output 5   retired flag register {Z,N,E,G,L}
REQ-006 The block SHALL have the following debug read port:
  dbg_addr  input  3   register select
  dbg_data  output 32  combinational read of the selected register

Function
REQ-007 Instruction fields SHALL be:
  [31:28] opcode
  [27:25] rd
  [24:22] rs1
  [21:19] rs2
  [16] imm_sel
  [15:0] imm
REQ-008 Legal opcodes SHALL be 0..9: Add, Sub, SL, SR, AND, OR, XOR, NAND, NOT, NOR; alu_ctrl SHALL equal the opcode.
REQ-009 Opcodes 10..15 SHALL be illegal.
REQ-010 The register file SHALL be 8 x 32 bits.
REQ-011 r0 SHALL read as 0, and writes to r0 SHALL be discarded.
REQ-012 alu_a SHALL be R[rs1].
REQ-013 alu_b SHALL be the sign-extended imm when imm_sel=1, else R[rs2].
REQ-014 The FSM SHALL have the states IDLE, EXEC and WB, with transitions:
  IDLE -> EXEC on in_valid & in_ready, legal opcode
  IDLE -> WB on in_valid & in_ready, illegal opcode
  EXEC -> WB unconditionally
  WB -> IDLE unconditionally
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 in_instr SHALL be sampled only on a handshake, and in_valid outside IDLE SHALL be ignored with nothing lost: the source holds it.
REQ-017 alu_ctrl/alu_a/alu_b SHALL be registered, loaded at the accept edge, and held stable throughout EXEC.
REQ-018 alu_res and the five ALU flags SHALL be captured at the EXEC->WB edge.
REQ-019 In WB, done=1 for exactly one cycle; R[rd] and flags SHALL update at the WB->IDLE edge.
REQ-020 Latency SHALL be fixed: accept at edge k -> done high in cycle k+2 -> in_ready high again in cycle k+3.
REQ-021 Throughput SHALL be one instruction per 3 cycles.
REQ-022 An illegal opcode SHALL set err=1 with done.
REQ-023 An illegal opcode SHALL leave the register file, flags and alu_* outputs unchanged.
REQ-024 When rd equals rs1 or rs2, the operand SHALL be the pre-write value; the result becomes visible to the next instruction.
REQ-025 dbg_data SHALL reflect a WB write from the cycle after the WB->IDLE edge.
REQ-026 Shift amounts SHALL be passed unmodified; SL/SR width handling belongs to the ALU.
REQ-027 err SHALL be 0 whenever done=0.

Reset
REQ-028 Asserting rst SHALL immediately force state IDLE and the following output values:
  done=0, err=0
  flags=5'b0
  alu_ctrl=0, alu_a=0, alu_b=0
  all registers = 0
REQ-029 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-030 Reset mid-instruction (in EXEC or WB) SHALL abort the instruction with no writeback and no done pulse.

Verification
REQ-031 Scenario: R1=5 (Add r1,r0,imm 5), then Add r2,r1,imm -5 -> done at k+2; R2=0; flags Z=1, E=0.
REQ-032 Scenario: R1=0xF0, SR r3,r1,imm 4 -> R3=0x0F; then NOT r4,r3 -> R4=0xFFFFFFF0; N flag per ALU.
REQ-033 Scenario: opcode 12 with rd=3 -> done=1 and err=1 in the same cycle; R3 and flags unchanged; alu_* unchanged.
REQ-034 Scenario: in_valid held high continuously over 4 instructions -> exactly 4 done pulses, spaced 3 cycles apart; in_ready high only in IDLE.
REQ-035 Scenario: Add r0,r1,r1 with R1=7 -> dbg_addr=0 reads 0; flags still update with E=1.
REQ-036 Scenario: rst asserted in EXEC -> no done pulse; all registers, flags and alu_* are 0; the next instruction executes normally.
